// File: rtl/dca_matrix_step_scheduler.sv
// Matrix step sequencer: queues step instructions, gathers operands, issues, awaits done, optional store hand-off.
// Optional performance counters are built only when DCA_STEP_SCHEDULER_PERF_EN is defined.
module dca_matrix_step_scheduler #(
    parameter int NUM_LOAD    = 3,
    parameter int BW_PAYLOAD  = 8,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clear,
    input  logic                         i_enable,
    output logic                         o_busy,
    input  logic                         i_inst_wvalid,
    output logic                         o_inst_wready,
    input  logic [NUM_LOAD+BW_PAYLOAD:0] i_inst_wdata,
    input  logic [NUM_LOAD-1:0]          i_loadreg_rready,
    output logic [NUM_LOAD-1:0]          o_loadreg_rrequest,
    output logic                         o_step_valid,
    input  logic                         i_step_ready,
    output logic [BW_PAYLOAD-1:0]        o_step_payload,
    input  logic                         i_step_done,
    input  logic                         i_storereg_wready,
    output logic                         o_storereg_wrequest,
    output logic [31:0]                  o_perf_step_count,
    output logic [31:0]                  o_perf_stall_count
);
    localparam int IW = 1 + NUM_LOAD + BW_PAYLOAD;
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam logic [AW-1:0] LP_PTR_ONE = AW'(1);
    localparam logic [AW:0]   LP_CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   LP_DEPTH   = (AW+1)'(QUEUE_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_OP,
        S_ISSUE,
        S_WAIT_DONE,
        S_WAIT_ST
    } state_t;

    state_t          r_state;
    logic            r_step_vld;
    logic            r_done_pending;
    logic            r_head_vld;
    logic [IW-1:0]   r_mem [QUEUE_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    logic [IW-1:0]         w_head;
    logic                  w_head_st;
    logic [NUM_LOAD-1:0]   w_head_mask;
    logic [BW_PAYLOAD-1:0] w_head_pl;
    logic                  w_adv;
    logic                  w_ops_ok;
    logic                  w_hs;
    logic                  w_done_evt;
    logic                  w_st_req;
    logic                  w_retire;
    logic                  w_push;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_st   = w_head[IW-1];
    assign w_head_mask = w_head[BW_PAYLOAD +: NUM_LOAD];
    assign w_head_pl   = w_head[BW_PAYLOAD-1:0];

    // clear outranks enable, so every advancing action is gated by both
    assign w_adv      = i_enable & ~i_clear;
    assign w_ops_ok   = &(i_loadreg_rready | ~w_head_mask);
    assign w_hs       = (r_state == S_ISSUE) & r_step_vld & i_step_ready & w_adv;
    assign w_done_evt = i_step_done | r_done_pending;
    assign w_st_req   = (r_state == S_WAIT_ST) & i_storereg_wready & w_adv;
    assign w_retire   = w_st_req | ((r_state == S_WAIT_DONE) & w_done_evt & ~w_head_st & w_adv);

    assign o_inst_wready       = ~rst & i_enable & ~i_clear & (r_count != LP_DEPTH);
    assign w_push              = i_inst_wvalid & o_inst_wready;
    assign o_busy              = (r_count != '0) | (r_state != S_IDLE);
    assign o_step_valid        = r_step_vld;
    assign o_step_payload      = r_step_vld ? w_head_pl : '0;
    assign o_loadreg_rrequest  = w_hs ? w_head_mask : '0;
    assign o_storereg_wrequest = w_st_req;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_inst_wdata;
        end
    end

    // r_head_vld lags the occupancy by a cycle so a fresh entry is seen by IDLE one cycle after it lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_head_vld <= 1'b0;
        end else if (i_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_head_vld <= 1'b0;
        end else begin
            r_head_vld <= (r_count != '0);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_retire) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end
            if (w_push && !w_retire) begin
                r_count <= r_count + LP_CNT_ONE;
            end else if (!w_push && w_retire) begin
                r_count <= r_count - LP_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_step_vld     <= 1'b0;
            r_done_pending <= 1'b0;
        end else if (i_clear) begin
            r_state        <= S_IDLE;
            r_step_vld     <= 1'b0;
            r_done_pending <= 1'b0;
        end else begin
            // a done that cannot be consumed right now is remembered until WAIT_DONE runs enabled
            if (i_step_done && !((r_state == S_WAIT_DONE) && i_enable)) begin
                r_done_pending <= 1'b1;
            end
            if (i_enable) begin
                case (r_state)
                    S_IDLE: begin
                        if (r_head_vld && (r_count != '0)) begin
                            r_state <= S_WAIT_OP;
                        end
                    end
                    S_WAIT_OP: begin
                        if (w_ops_ok) begin
                            r_state    <= S_ISSUE;
                            r_step_vld <= 1'b1;
                        end
                    end
                    S_ISSUE: begin
                        if (i_step_ready) begin
                            r_state    <= S_WAIT_DONE;
                            r_step_vld <= 1'b0;
                        end
                    end
                    S_WAIT_DONE: begin
                        if (w_done_evt) begin
                            r_done_pending <= 1'b0;
                            r_state        <= w_head_st ? S_WAIT_ST : S_IDLE;
                        end
                    end
                    S_WAIT_ST: begin
                        if (i_storereg_wready) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef DCA_STEP_SCHEDULER_PERF_EN
    logic [31:0] r_step_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = (r_state == S_WAIT_OP) & w_adv & ~w_ops_ok;

    // counters survive clear and saturate instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_retire && (r_step_cnt != 32'hFFFF_FFFF)) begin
                r_step_cnt <= r_step_cnt + 32'd1;
            end
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign o_perf_step_count  = r_step_cnt;
    assign o_perf_stall_count = r_stall_cnt;
`else
    assign o_perf_step_count  = '0;
    assign o_perf_stall_count = '0;
`endif

endmodule

// File: tb/tb_dca_matrix_step_scheduler.sv
// Bench for dca_matrix_step_scheduler: directed steps, scoreboard of expected issues checked by an output monitor.
module tb_dca_matrix_step_scheduler;
`ifdef DCA_STEP_SCHEDULER_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_clear = 1'b0;
    logic        i_enable = 1'b1;
    logic        o_busy;
    logic        i_inst_wvalid = 1'b0;
    logic        o_inst_wready;
    logic [11:0] i_inst_wdata = '0;
    logic [2:0]  i_loadreg_rready = '0;
    logic [2:0]  o_loadreg_rrequest;
    logic        o_step_valid;
    logic        i_step_ready = 1'b0;
    logic [7:0]  o_step_payload;
    logic        i_step_done = 1'b0;
    logic        i_storereg_wready = 1'b0;
    logic        o_storereg_wrequest;
    logic [31:0] o_perf_step_count;
    logic [31:0] o_perf_stall_count;

    typedef struct {
        logic [7:0] pl;
        logic [2:0] mask;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   wreq_pulses = 0;

    dca_matrix_step_scheduler #(
        .NUM_LOAD(3),
        .BW_PAYLOAD(8),
        .QUEUE_DEPTH(4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_clear            (i_clear),
        .i_enable           (i_enable),
        .o_busy             (o_busy),
        .i_inst_wvalid      (i_inst_wvalid),
        .o_inst_wready      (o_inst_wready),
        .i_inst_wdata       (i_inst_wdata),
        .i_loadreg_rready   (i_loadreg_rready),
        .o_loadreg_rrequest (o_loadreg_rrequest),
        .o_step_valid       (o_step_valid),
        .i_step_ready       (i_step_ready),
        .o_step_payload     (o_step_payload),
        .i_step_done        (i_step_done),
        .i_storereg_wready  (i_storereg_wready),
        .o_storereg_wrequest(o_storereg_wrequest),
        .o_perf_step_count  (o_perf_step_count),
        .o_perf_stall_count (o_perf_stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic st, input logic [2:0] m, input logic [7:0] pl, input bit expect_accept);
        exp_t x;
        i_inst_wvalid = 1'b1;
        i_inst_wdata  = {st, m, pl};
        if (expect_accept) begin
            x.pl   = pl;
            x.mask = m;
            sb.push_back(x);
        end
        tick();
        i_inst_wvalid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!o_step_valid && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (!o_step_valid) begin
            bad++;
            $display("FAIL %s: step_valid still 0 after 20 cycles, expected 1", name);
        end
    endtask

    task automatic done_pulse();
        i_step_done = 1'b1;
        tick();
        i_step_done = 1'b0;
    endtask

    // issue monitor and pulse-rule monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (o_step_valid && i_step_ready && i_enable && !i_clear) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL issue_unexpected: payload %0h issued, expected no issue", o_step_payload);
                end else begin
                    mon_e = sb.pop_front();
                    if (o_step_payload !== mon_e.pl || o_loadreg_rrequest !== mon_e.mask) begin
                        bad++;
                        $display("FAIL issue_order: payload %0h rrequest %b, expected payload %0h rrequest %b",
                                 o_step_payload, o_loadreg_rrequest, mon_e.pl, mon_e.mask);
                    end
                end
            end
            if (!i_enable || i_clear) begin
                total++;
                if (o_loadreg_rrequest != 3'b000 || o_storereg_wrequest) begin
                    bad++;
                    $display("FAIL pulse_rule: rrequest %b wrequest %b, expected 0 0",
                             o_loadreg_rrequest, o_storereg_wrequest);
                end
            end
            if (o_storereg_wrequest) wreq_pulses++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls_seen;
        logic [2:0] m3 [4];
        m3[0] = 3'b001; m3[1] = 3'b010; m3[2] = 3'b100; m3[3] = 3'b000;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_wready", 32'(o_inst_wready), 32'd0);
        check("rst_step_valid", 32'(o_step_valid), 32'd0);
        check("rst_rrequest", 32'(o_loadreg_rrequest), 32'd0);
        check("rst_wrequest", 32'(o_storereg_wrequest), 32'd0);
        check("rst_perf_step", o_perf_step_count, 32'd0);
        check("rst_perf_stall", o_perf_stall_count, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_wready", 32'(o_inst_wready), 32'd1);
        tick();

        // T1: basic issue latency and single-cycle operand consume
        i_loadreg_rready = 3'b011;
        i_step_ready     = 1'b1;
        push(1'b0, 3'b011, 8'hA5, 1'b1);
        tick();
        check("t1_valid_n1", 32'(o_step_valid), 32'd0);
        tick();
        check("t1_valid_n2", 32'(o_step_valid), 32'd0);
        tick();
        check("t1_valid_n3", 32'(o_step_valid), 32'd1);
        check("t1_payload", 32'(o_step_payload), 32'hA5);
        check("t1_rrequest", 32'(o_loadreg_rrequest), 32'b011);
        tick();
        check("t1_rrequest_gone", 32'(o_loadreg_rrequest), 32'd0);
        check("t1_valid_gone", 32'(o_step_valid), 32'd0);
        check("t1_busy_wait_done", 32'(o_busy), 32'd1);
        done_pulse();
        check("t1_busy_after_done", 32'(o_busy), 32'd0);
        check("t1_perf_step", o_perf_step_count, 32'(PERF * 1));

        // T2: missing operand stalls for exactly 10 evaluated cycles
        i_loadreg_rready = 3'b101;
        push(1'b0, 3'b111, 8'h3C, 1'b1);
        stalls_seen = 0;
        repeat (12) begin
            tick();
            if (o_step_valid) stalls_seen++;
        end
        check("t2_no_early_issue", 32'(stalls_seen), 32'd0);
        i_loadreg_rready = 3'b111;
        tick();
        check("t2_issue", 32'(o_step_valid), 32'd1);
        check("t2_perf_stall", o_perf_stall_count, 32'(PERF * 10));
        tick();
        done_pulse();
        check("t2_busy", 32'(o_busy), 32'd0);
        check("t2_perf_step", o_perf_step_count, 32'(PERF * 2));

        // T3: fill queue with datapath stalled, 5th push refused, in-order retire
        i_step_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t3_wready_free", 32'(o_inst_wready), 32'd1);
            push(1'b0, m3[i], 8'h10 + 8'(i), 1'b1);
        end
        check("t3_wready_full", 32'(o_inst_wready), 32'd0);
        push(1'b0, 3'b111, 8'hEE, 1'b0);
        check("t3_wready_still_full", 32'(o_inst_wready), 32'd0);
        i_step_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid("t3_wait_valid");
            tick();
            done_pulse();
        end
        check("t3_busy", 32'(o_busy), 32'd0);
        check("t3_sb_empty", 32'(sb.size()), 32'd0);
        check("t3_perf_step", o_perf_step_count, 32'(PERF * 6));

        // T4: store hand-off waits for store path ready
        wreq_pulses = 0;
        push(1'b1, 3'b001, 8'h77, 1'b1);
        wait_valid("t4_wait_valid");
        tick();
        done_pulse();
        repeat (5) tick();
        check("t4_busy_wait_st", 32'(o_busy), 32'd1);
        check("t4_no_early_wreq", 32'(wreq_pulses), 32'd0);
        i_storereg_wready = 1'b1;
        #1;
        check("t4_wrequest", 32'(o_storereg_wrequest), 32'd1);
        tick();
        i_storereg_wready = 1'b0;
        #1;
        check("t4_wrequest_gone", 32'(o_storereg_wrequest), 32'd0);
        check("t4_busy", 32'(o_busy), 32'd0);
        check("t4_wreq_pulses", 32'(wreq_pulses), 32'd1);
        check("t4_perf_step", o_perf_step_count, 32'(PERF * 7));
        tick();

        // T5: enable low holds step_valid and latches an early done
        i_step_ready = 1'b0;
        push(1'b0, 3'b000, 8'h55, 1'b1);
        wait_valid("t5_wait_valid");
        i_enable     = 1'b0;
        i_step_ready = 1'b1;
        #1;
        check("t5_wready_disabled", 32'(o_inst_wready), 32'd0);
        tick();
        tick();
        check("t5_valid_held", 32'(o_step_valid), 32'd1);
        check("t5_payload_held", 32'(o_step_payload), 32'h55);
        i_enable = 1'b1;
        tick();
        i_enable = 1'b0;
        done_pulse();
        tick();
        tick();
        check("t5_busy_pending", 32'(o_busy), 32'd1);
        i_enable = 1'b1;
        tick();
        check("t5_busy_retired", 32'(o_busy), 32'd0);
        check("t5_perf_step", o_perf_step_count, 32'(PERF * 8));
        check("t5_perf_stall", o_perf_stall_count, 32'(PERF * 10));

        // T6a: clear while issuing with three queued steps
        i_step_ready = 1'b0;
        push(1'b0, 3'b011, 8'h61, 1'b1);
        push(1'b0, 3'b011, 8'h62, 1'b1);
        push(1'b0, 3'b011, 8'h63, 1'b1);
        wait_valid("t6_wait_valid");
        i_clear      = 1'b1;
        i_step_ready = 1'b1;
        #1;
        check("t6_clear_rrequest", 32'(o_loadreg_rrequest), 32'd0);
        check("t6_clear_wready", 32'(o_inst_wready), 32'd0);
        tick();
        i_clear      = 1'b0;
        i_step_ready = 1'b0;
        sb.delete();
        check("t6_busy_after_clear", 32'(o_busy), 32'd0);
        check("t6_valid_after_clear", 32'(o_step_valid), 32'd0);
        check("t6_perf_kept", o_perf_step_count, 32'(PERF * 8));
        repeat (5) tick();
        check("t6_queue_empty", 32'(o_step_valid), 32'd0);

        // T6b: asynchronous reset while waiting for done
        i_step_ready = 1'b1;
        push(1'b1, 3'b000, 8'h99, 1'b1);
        wait_valid("t6_rst_wait_valid");
        tick();
        i_step_ready = 1'b0;
        check("t6_busy_before_rst", 32'(o_busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_busy", 32'(o_busy), 32'd0);
        check("t6_rst_valid", 32'(o_step_valid), 32'd0);
        check("t6_rst_wready", 32'(o_inst_wready), 32'd0);
        check("t6_rst_perf_step", o_perf_step_count, 32'd0);
        check("t6_rst_perf_stall", o_perf_stall_count, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("t6_post_rst_wready", 32'(o_inst_wready), 32'd1);
        check("t6_post_rst_busy", 32'(o_busy), 32'd0);

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
